// File: rtl/bin2dec_arb_pkg.sv
// Shared types and defaults for the bin2dec request arbiter.
// Provides the controller state encoding and a grant-index width helper.
package bin2dec_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 63;

    typedef enum logic [2:0] {
        S_FLUSH   = 3'd0,
        S_IDLE    = 3'd1,
        S_LAUNCH  = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    // Bits needed to index n requesters (never below one bit).
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req_i (request vector), ptr_i (start index), idx_o, valid_o.
module rr_pick
    import bin2dec_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]          req_i,
    input  logic [idx_w(N)-1:0]   ptr_i,
    output logic [idx_w(N)-1:0]   idx_o,
    output logic                  valid_o
);

    localparam int IW = idx_w(N);
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] pos;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k wrapped modulo N without a divider
            sum = {1'b0, ptr_i} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            pos = sum[IW-1:0];
            if (!valid_o && req_i[pos]) begin
                valid_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/bin2dec_arbiter.sv
// Shares one bin2dec converter between NUM_REQ requesters, round-robin.
// Ports: clk, rst; req/req_din in, ack/res_dout/res_id/err out;
// conv_start/conv_din to converter, conv_done/conv_dout from it.
module bin2dec_arbiter
    import bin2dec_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [16*NUM_REQ-1:0]      req_din,
    output logic [NUM_REQ-1:0]         ack,
    output logic [15:0]                res_dout,
    output logic [idx_w(NUM_REQ)-1:0]  res_id,
    output logic                       err,
    output logic                       conv_start,
    output logic [15:0]                conv_din,
    input  logic                       conv_done,
    input  logic [15:0]                conv_dout
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       grant_q;
    logic [TW-1:0]       tmo_q;
    logic                flush_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [15:0]         res_dout_q;
    logic [IW-1:0]       res_id_q;
    logic                err_q;
    logic                start_q;
    logic [15:0]         din_q;

    logic [IW-1:0]       pick_idx;
    logic                pick_vld;
    logic [15:0]         pick_din_d;
    logic [IW-1:0]       ptr_d;
    logic [NUM_REQ-1:0]  ack_d;
    logic                tmo_hit;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    always_comb begin
        pick_din_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_din_d = req_din[16*i +: 16];
            end
        end
    end

    always_comb begin
        ack_d          = '0;
        ack_d[grant_q] = 1'b1;
    end

    assign ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FLUSH;
            ptr_q      <= '0;
            grant_q    <= '0;
            tmo_q      <= '0;
            flush_q    <= 1'b0;
            ack_q      <= '0;
            res_dout_q <= '0;
            res_id_q   <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            din_q      <= '0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            unique case (state_q)
                S_FLUSH: begin
                    // converter has no reset: need done on two
                    // consecutive cycles so it has drained to idle
                    start_q <= 1'b0;
                    if (conv_done) begin
                        flush_q <= 1'b1;
                        if (flush_q) begin
                            flush_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_idx;
                        din_q   <= pick_din_d;
                        start_q <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH, S_WAIT: begin
                    if (state_q == S_LAUNCH && !conv_done) begin
                        tmo_q   <= '0;
                        state_q <= S_WAIT;
                    end else if (state_q == S_WAIT && conv_done) begin
                        state_q <= S_CAPTURE;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        start_q <= 1'b0;
                        ptr_q   <= ptr_d;
                        flush_q <= 1'b0;
                        state_q <= S_FLUSH;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    res_dout_q <= conv_dout;
                    res_id_q   <= grant_q;
                    ack_q      <= ack_d;
                    start_q    <= 1'b0;
                    ptr_q      <= ptr_d;
                    state_q    <= S_RELEASE;
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_FLUSH;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign res_dout   = res_dout_q;
    assign res_id     = res_id_q;
    assign err        = err_q;
    assign conv_start = start_q;
    assign conv_din   = din_q;

endmodule

// File: tb/tb_bin2dec_arbiter.sv
// Directed bench for bin2dec_arbiter with a behavioural bin2dec model.
// Converter: idle/done drive done=1, busy for LAT cycles drives done=0.
module tb_bin2dec_arbiter;

    localparam int NR  = 4;
    localparam int TO  = 63;
    localparam int LAT = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [16*NR-1:0]  req_din;
    logic [NR-1:0]     ack;
    logic [15:0]       res_dout;
    logic [1:0]        res_id;
    logic              err;
    logic              conv_start;
    logic [15:0]       conv_din;
    logic              conv_done;
    logic [15:0]       conv_dout;

    int checks   = 0;
    int failures = 0;
    int lat;
    int n;
    bit started;
    bit anyack;

    always #5 clk = ~clk;

    bin2dec_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_din    (req_din),
        .ack        (ack),
        .res_dout   (res_dout),
        .res_id     (res_id),
        .err        (err),
        .conv_start (conv_start),
        .conv_din   (conv_din),
        .conv_done  (conv_done),
        .conv_dout  (conv_dout)
    );

    // bin2dec model: (din*1000)>>16 as three BCD digits, no reset
    int          cst   = 0;
    int          ccnt  = 0;
    logic [15:0] cin   = '0;
    logic [15:0] cdout = '0;
    bit          stuck = 1'b0;

    function automatic logic [15:0] bcd(input logic [15:0] d);
        int v;
        v = int'((32'(d) * 32'd1000) >> 16);
        return {4'd0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk) begin
        case (cst)
            0: if (conv_start && !stuck) begin
                cst  <= 1;
                ccnt <= 0;
                cin  <= conv_din;
            end
            1: if (ccnt == LAT - 1) begin
                cst   <= 2;
                cdout <= bcd(cin);
            end else begin
                ccnt <= ccnt + 1;
            end
            default: if (!conv_start) cst <= 0;
        endcase
    end

    assign conv_done = (cst != 1);
    assign conv_dout = cdout;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input int i, input logic [15:0] v);
        req_din[16*i +: 16] = v;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"},   32'(ack), 0);
        chk({tag, "_res"},   32'(res_dout), 0);
        chk({tag, "_id"},    32'(res_id), 0);
        chk({tag, "_err"},   32'(err), 0);
        chk({tag, "_start"}, 32'(conv_start), 0);
        chk({tag, "_cdin"},  32'(conv_din), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for the next ack, check it, optionally drop the request.
    task automatic wait_ack(input int idx, input logic [15:0] exp,
                            input string tag, input bit drop,
                            output int l);
        bit s;
        s = 1'b0;
        l = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (s) l++;
            else if (conv_start) s = 1'b1;
            if (ack != '0) break;
        end
        chk({tag, "_ack"}, 32'(ack), 32'(1) << idx);
        chk({tag, "_res"}, 32'(res_dout), 32'(exp));
        chk({tag, "_id"},  32'(res_id), 32'(idx));
        if (drop) req[idx] = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_din = '0;
        @(posedge clk);
        @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;

        // single request
        set_din(0, 16'hFFFF);
        req[0] = 1'b1;
        wait_ack(0, 16'h0999, "t1", 1'b1, lat);
        chk("t1_lat", 32'(lat <= 20), 1);

        // all held: strict 0,1,2,3,0 order
        do_reset();
        set_din(0, 16'h0000);
        set_din(1, 16'h8000);
        set_din(2, 16'h4000);
        set_din(3, 16'hFFFF);
        req = 4'hF;
        wait_ack(0, 16'h0000, "t2a", 1'b0, lat);
        wait_ack(1, 16'h0500, "t2b", 1'b0, lat);
        wait_ack(2, 16'h0250, "t2c", 1'b0, lat);
        wait_ack(3, 16'h0999, "t2d", 1'b0, lat);
        wait_ack(0, 16'h0000, "t2e", 1'b1, lat);
        req = '0;

        // operand changes after grant are ignored
        set_din(2, 16'h8000);
        req[2] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (conv_start) break;
        end
        @(negedge clk);
        set_din(2, 16'h0000);
        wait_ack(2, 16'h0500, "t3", 1'b1, lat);

        // reset while converter busy
        set_din(1, 16'h1234);
        req[1] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!conv_done) break;
        end
        @(negedge clk);
        rst = 1'b1;
        set_din(1, 16'hFFFF);
        @(negedge clk);
        chk_reset("t4rst");
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (conv_done) break;
            chk("t4_hold", {30'd0, conv_start, |ack}, 0);
            @(negedge clk);
        end
        wait_ack(1, 16'h0999, "t4", 1'b1, lat);

        // stuck converter: timeout, then next pending served
        stuck = 1'b1;
        set_din(0, 16'h4000);
        set_din(1, 16'h8000);
        req     = 4'b0011;
        n       = 0;
        started = 1'b0;
        anyack  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ack != '0) anyack = 1'b1;
            if (started) n++;
            else if (conv_start) started = 1'b1;
            if (err) break;
        end
        chk("t5_err", 32'(err), 1);
        chk("t5_err_lat", 32'(n), TO + 1);
        chk("t5_noack", 32'(anyack), 0);
        stuck = 1'b0;
        @(negedge clk);
        chk("t5_err_pulse", 32'(err), 0);
        chk("t5_start_off", 32'(conv_start), 0);
        wait_ack(1, 16'h0500, "t5b", 1'b1, lat);
        wait_ack(0, 16'h0250, "t5c", 1'b1, lat);

        // pointer wrap 3 -> 0
        set_din(3, 16'h1234);
        req = 4'b1000;
        wait_ack(3, 16'h0071, "t6a", 1'b1, lat);
        set_din(0, 16'hFFFF);
        req[0] = 1'b1;
        wait_ack(0, 16'h0999, "t6b", 1'b1, lat);
        anyack = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ack != '0) anyack = 1'b1;
        end
        chk("t6_nodup", 32'(anyack), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
